// File: rtl/breath_led_seq.sv
// breath_led_seq: chases a breathing-LED waveform across LED_NUM channels,
// one channel breathing at a time. A shared 1us/1ms/1s time base drives a
// PWM compare. A three-state FSM handles start/stop requests that arrive as
// one-cycle pulses from the key debouncer.
//
// Build option: define LED_ACTIVE_LOW_EN for boards with LEDs wired to VCC.
// With it defined, led_out is the inverse of the active-high drive: it resets
// to all ones, and inactive LEDs are held at 1.

module breath_led_seq #(
    parameter logic [5:0] CNT_1US_MAX = 6'd49,   // sys_clk cycles per 1us tick, minus 1
    parameter logic [9:0] CNT_1MS_MAX = 10'd999, // 1us ticks per 1ms PWM period, minus 1
    parameter logic [9:0] CNT_1S_MAX  = 10'd999, // 1ms periods per half-breath, minus 1
    parameter int         LED_NUM     = 4        // number of LED channels (2..8)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start_pulse,
    input  logic               stop_pulse,
    input  logic               dir,
    output logic [LED_NUM-1:0] led_out,
    output logic               busy,
    output logic               breath_done
);

    localparam int                CH_W    = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(LED_NUM - 1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [LED_NUM-1:0] LED_POL = '1;
`else
    localparam logic [LED_NUM-1:0] LED_POL = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [5:0]         cnt_1us;
    logic [9:0]         cnt_1ms;
    logic [9:0]         cnt_1s;
    logic               phase;      // 0 = inhale, 1 = exhale
    logic [CH_W-1:0]    ch;

    logic               us_wrap;
    logic               ms_wrap;
    logic               s_wrap;
    logic               breath_end;
    logic               pwm_on;
    logic [LED_NUM-1:0] led_level;

    // Wrap strobes of the cascaded time base. A breath ends when the 1s
    // counter wraps during the exhale phase.
    assign us_wrap    = (cnt_1us == CNT_1US_MAX);
    assign ms_wrap    = us_wrap && (cnt_1ms == CNT_1MS_MAX);
    assign s_wrap     = ms_wrap && (cnt_1s == CNT_1S_MAX);
    assign breath_end = s_wrap && phase;

    // Inhale: the duty cycle grows with cnt_1s. Exhale: it shrinks again.
    assign pwm_on = phase ? (cnt_1ms >= cnt_1s) : (cnt_1ms < cnt_1s);

    // Next chase channel. It wraps at both ends, and dir is sampled at the
    // moment of the advance.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c,
                                                input logic            d);
        if (!d) begin
            return (c == CH_LAST) ? '0 : c + CH_W'(1);
        end
        return (c == '0) ? CH_LAST : c - CH_W'(1);
    endfunction

    // Active-high drive level: only the current channel carries the PWM.
    always_comb begin
        // NOTE: default every bit first so no path leaves led_level unassigned (no latch).
        led_level = '0;
        if (state != IDLE) begin
            led_level[ch] = pwm_on;
        end
    end

    // Time base, sequencing FSM and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: every register, outputs included, has an async reset value; nothing here is a memory array.
            state       <= IDLE;
            cnt_1us     <= '0;
            cnt_1ms     <= '0;
            cnt_1s      <= '0;
            phase       <= 1'b0;
            ch          <= '0;
            busy        <= 1'b0;
            breath_done <= 1'b0;
            led_out     <= LED_POL;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
            breath_done <= 1'b0;
            led_out     <= led_level ^ LED_POL;

            if (state == IDLE) begin
                cnt_1us <= '0;
                cnt_1ms <= '0;
                cnt_1s  <= '0;
                phase   <= 1'b0;
            end else begin
                cnt_1us <= us_wrap ? '0 : cnt_1us + 6'd1;
                if (us_wrap) begin
                    cnt_1ms <= ms_wrap ? '0 : cnt_1ms + 10'd1;
                end
                if (ms_wrap) begin
                    cnt_1s <= s_wrap ? '0 : cnt_1s + 10'd1;
                end
                if (s_wrap) begin
                    phase <= ~phase;
                end
                if (breath_end) begin
                    breath_done <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // A simultaneous stop cancels the start.
                    if (start_pulse && !stop_pulse) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        ch    <= dir ? CH_LAST : '0;
                    end
                end
                RUN: begin
                    if (breath_end) begin
                        ch <= next_ch(ch, dir);
                    end
                    // A stop on the boundary cycle still advances the channel,
                    // so FINISH plays one full breath on the new channel.
                    if (stop_pulse) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (breath_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_breath_led_seq.sv
// Directed bench for breath_led_seq. It uses a shrunk time base: 5 clocks
// per us, 10 us per ms and 10 ms per half-breath, so one breath is 1000
// clocks. Sample index t counts negedges after the start edge. The LED value
// seen at sample t comes from time-base count t-1.

module tb_breath_led_seq;

    localparam int N = 4;
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N-1:0] POL = 4'hF;
`else
    localparam logic [N-1:0] POL = 4'h0;
`endif

    logic         sys_clk     = 1'b0;
    logic         sys_rst_n   = 1'b0;
    logic         start_pulse = 1'b0;
    logic         stop_pulse  = 1'b0;
    logic         dir         = 1'b0;
    logic [N-1:0] led_out;
    logic         busy;
    logic         breath_done;

    int           checks = 0;
    int           errors = 0;

    // Per-run trackers, filled in on every sampled cycle.
    int           t;
    logic [N-1:0] mask_b [0:7];   // OR of LED drive for each breath
    int           win    [0:19];  // LED-on clocks per 50-clock window of breath 0
    int           bd_q   [$];     // sample indices with breath_done high
    int           busy_hi;

    always #10 sys_clk = ~sys_clk;

    breath_led_seq #(
        .CNT_1US_MAX (6'd4),
        .CNT_1MS_MAX (10'd9),
        .CNT_1S_MAX  (10'd9),
        .LED_NUM     (N)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .dir         (dir),
        .led_out     (led_out),
        .busy        (busy),
        .breath_done (breath_done)
    );

    function automatic logic [N-1:0] led();
        return led_out ^ POL;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_track();
        t = 0;
        busy_hi = 0;
        bd_q.delete();
        for (int i = 0; i < 8; i++) mask_b[i] = '0;
        for (int i = 0; i < 20; i++) win[i] = 0;
    endtask

    task automatic step();
        @(negedge sys_clk);
        t++;
        if ((t - 1) / 1000 < 8) mask_b[(t - 1) / 1000] |= led();
        if (t <= 1000 && led() != '0) win[(t - 1) / 50]++;
        if (breath_done === 1'b1) bd_q.push_back(t);
        if (busy === 1'b1) busy_hi++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic start_run(input logic d);
        dir = d;
        start_pulse = 1'b1;
        @(negedge sys_clk);
        start_pulse = 1'b0;
        clear_track();
        check("busy_after_start", 32'(busy), 1);
        check("led_at_start", 32'(led()), 0);
    endtask

    task automatic pulse_stop();
        stop_pulse = 1'b1;
        step();
        stop_pulse = 1'b0;
    endtask

    initial begin
        int sum;

        // Reset state and a long idle period.
        repeat (3) @(negedge sys_clk);
        check("rst_led", 32'(led()), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(breath_done), 0);
        sys_rst_n = 1'b1;
        clear_track();
        run_to(2000);
        check("idle_led_mask", 32'(mask_b[0] | mask_b[1]), 0);
        check("idle_done_cnt", bd_q.size(), 0);
        check("idle_busy_cnt", busy_hi, 0);

        // Ascending chase across five breaths.
        start_run(1'b0);
        run_to(4700);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("inhale_win%0d", k), win[k], k * 5);
            check($sformatf("exhale_win%0d", k), win[10 + k], (10 - k) * 5);
        end
        check("asc_done_cnt", bd_q.size(), 4);
        for (int i = 0; i < 4 && i < bd_q.size(); i++)
            check($sformatf("asc_done_t%0d", i), bd_q[i], (i + 1) * 1000);
        check("asc_led_b0", 32'(mask_b[0]), 1);
        check("asc_led_b1", 32'(mask_b[1]), 2);
        check("asc_led_b2", 32'(mask_b[2]), 4);
        check("asc_led_b3", 32'(mask_b[3]), 8);
        check("asc_led_b4", 32'(mask_b[4]), 1);
        check("asc_busy", 32'(busy), 1);

        // Asynchronous reset in the middle of the exhale phase.
        #5 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led()), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(breath_done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Fresh start, then a stop at clock 300 lets the breath complete.
        // A start during FINISH must be ignored.
        start_run(1'b0);
        run_to(300);
        pulse_stop();
        run_to(599);
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        run_to(1001);
        sum = 0;
        for (int k = 0; k < 10; k++) sum += win[k];
        check("restart_inhale_sum", sum, 225);
        check("restart_win1", win[1], 5);
        check("stop_led_b0", 32'(mask_b[0]), 1);
        check("stop_done_cnt", bd_q.size(), 1);
        if (bd_q.size() > 0) check("stop_done_t", bd_q[0], 1000);
        check("stop_busy_after", 32'(busy), 0);
        check("stop_led_after", 32'(led()), 0);
        run_to(1100);
        check("stop_idle_done_cnt", bd_q.size(), 1);
        check("stop_idle_led", 32'(mask_b[1]), 0);

        // Start and stop together while IDLE: stop wins.
        start_pulse = 1'b1;
        stop_pulse  = 1'b1;
        @(negedge sys_clk);
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        check("start_stop_busy", 32'(busy), 0);
        repeat (20) @(negedge sys_clk);
        check("start_stop_busy_late", 32'(busy), 0);
        check("start_stop_led", 32'(led()), 0);

        // Descending chase. dir flips mid-breath and takes effect at the boundary.
        start_run(1'b1);
        run_to(1500);
        dir = 1'b0;
        run_to(2500);
        pulse_stop();
        run_to(3001);
        check("desc_led_b0", 32'(mask_b[0]), 8);
        check("desc_led_b1", 32'(mask_b[1]), 4);
        check("flip_led_b2", 32'(mask_b[2]), 8);
        check("desc_done_cnt", bd_q.size(), 3);
        if (bd_q.size() == 3) check("desc_done_t2", bd_q[2], 3000);
        check("desc_busy_after", 32'(busy), 0);
        check("desc_led_after", 32'(led()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
